// File: rtl/alu_sched.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Define ALU_SCHED_MULTISHIFT_EN for iterative multi-bit shifts; otherwise shifts move one bit.
module alu_sched #(
  parameter int NBIT = 16,
  parameter int SHW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [2:0]      req0_sel,
  input  logic [NBIT-1:0] req0_a,
  input  logic [NBIT-1:0] req0_b,
  input  logic [SHW-1:0]  req0_shamt,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [2:0]      req1_sel,
  input  logic [NBIT-1:0] req1_a,
  input  logic [NBIT-1:0] req1_b,
  input  logic [SHW-1:0]  req1_shamt,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_id,
  output logic [NBIT-1:0] res_data,
  output logic [NBIT-1:0] alu_a,
  output logic [NBIT-1:0] alu_b,
  output logic [2:0]      alu_sel,
  output logic            alu_shin,
  input  logic [NBIT-1:0] alu_out
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic            last;
  logic            id_r;
  logic [2:0]      sel_r;
  logic [NBIT-1:0] acc;
  logic [NBIT-1:0] b_r;
  logic [NBIT-1:0] data_r;
  logic            win;
  logic            accept;
  logic            is_shift;

  // Winner is the requester not granted last when both are valid.
  always_comb begin
    win = 1'b0;
    if (req0_valid && req1_valid)
      win = ~last;
    else if (req1_valid)
      win = 1'b1;
  end

  assign accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !win;
  assign req1_ready = accept && win;
  assign is_shift   = (sel_r[2:1] == 2'b11);

  assign alu_a     = acc;
  assign alu_b     = b_r;
  assign alu_sel   = sel_r;
  assign res_valid = (state == RESP);
  assign res_id    = id_r;
  assign res_data  = data_r;

`ifdef ALU_SCHED_MULTISHIFT_EN
  logic [SHW-1:0] cnt;

  assign alu_shin = (state == EXEC) && is_shift && (cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= 1'b1;
      id_r   <= 1'b0;
      sel_r  <= '0;
      acc    <= '0;
      b_r    <= '0;
      data_r <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sel_r <= win ? req1_sel   : req0_sel;
            acc   <= win ? req1_a     : req0_a;
            b_r   <= win ? req1_b     : req0_b;
            cnt   <= win ? req1_shamt : req0_shamt;
            id_r  <= win;
            last  <= win;
            state <= EXEC;
          end
        end
        EXEC: begin
          // Each shift pass feeds the ALU result back as the next A operand.
          if (is_shift && (cnt != '0)) begin
            acc <= alu_out;
            cnt <= cnt - 1'b1;
            if (cnt == SHW'(1)) begin
              data_r <= alu_out;
              state  <= RESP;
            end
          end else begin
            data_r <= alu_out;
            state  <= RESP;
          end
        end
        RESP: begin
          if (res_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_shamt;

  assign unused_shamt = ^{req0_shamt, req1_shamt};
  assign alu_shin     = (state == EXEC) && is_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= 1'b1;
      id_r   <= 1'b0;
      sel_r  <= '0;
      acc    <= '0;
      b_r    <= '0;
      data_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sel_r <= win ? req1_sel : req0_sel;
            acc   <= win ? req1_a   : req0_a;
            b_r   <= win ? req1_b   : req0_b;
            id_r  <= win;
            last  <= win;
            state <= EXEC;
          end
        end
        EXEC: begin
          data_r <= alu_out;
          state  <= RESP;
        end
        RESP: begin
          if (res_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched with a behavioural ALU on the alu_* ports.
module tb_alu_sched;

`ifdef ALU_SCHED_MULTISHIFT_EN
  localparam bit MS = 1'b1;
`else
  localparam bit MS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]  req0_sel, req1_sel;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_shamt, req1_shamt;
  logic        res_valid, res_ready, res_id;
  logic [15:0] res_data, alu_a, alu_b, alu_out;
  logic [2:0]  alu_sel;
  logic        alu_shin;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sched #(.NBIT(16), .SHW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_shin(alu_shin), .alu_out(alu_out)
  );

  // Reference ALU: 110 shifts left, 111 shifts right, zero fill, pass-through when shin=0.
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      3'b000: alu_out = alu_a + alu_b;
      3'b001: alu_out = alu_a - alu_b;
      3'b010: alu_out = alu_a & alu_b;
      3'b011: alu_out = alu_a | alu_b;
      3'b100: alu_out = alu_a ^ alu_b;
      3'b101: alu_out = ~alu_a;
      3'b110: alu_out = alu_shin ? {alu_a[14:0], 1'b0} : alu_a;
      3'b111: alu_out = alu_shin ? {1'b0, alu_a[15:1]} : alu_a;
      default: alu_out = '0;
    endcase
  end

  typedef struct {
    bit          id;
    logic [2:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sh;
    logic [15:0] exp_ms;
    logic [15:0] exp_1;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit id, input logic v, input logic [2:0] sel,
                       input logic [15:0] a, input logic [15:0] b, input logic [3:0] sh);
    if (id) begin
      req1_valid = v; req1_sel = sel; req1_a = a; req1_b = b; req1_shamt = sh;
    end else begin
      req0_valid = v; req0_sel = sel; req0_a = a; req0_b = b; req0_shamt = sh;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output int shc);
    lat = 0;
    shc = 0;
    while (!res_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (alu_shin) shc++;
    end
  endtask

  task automatic do_op(input int idx, input vec_t v);
    int n, lat, shc, exp_sh, exp_lat;
    logic rdy;
    logic [15:0] exp;
    bit shift;
    shift = (v.sel[2:1] == 2'b11);
    exp = MS ? v.exp_ms : v.exp_1;
    if (MS) exp_sh = (shift && v.sh != 0) ? int'(v.sh) : 0;
    else    exp_sh = shift ? 1 : 0;
    exp_lat = ((exp_sh > 1) ? exp_sh : 1) + 1;
    @(negedge clk);
    drive(v.id, 1'b1, v.sel, v.a, v.b, v.sh);
    #1;
    n = 0;
    rdy = v.id ? req1_ready : req0_ready;
    while (!rdy && n < 10) begin
      @(negedge clk); #1;
      n++;
      rdy = v.id ? req1_ready : req0_ready;
    end
    check($sformatf("vec%0d accept", idx), 32'(rdy), 32'd1);
    @(posedge clk);
    #1 drive(v.id, 1'b0, 3'b101, 16'hDEAD, 16'hBEEF, 4'hF);
    wait_resp(lat, shc);
    check($sformatf("vec%0d latency", idx), lat, exp_lat);
    check($sformatf("vec%0d shin_cycles", idx), shc, exp_sh);
    check($sformatf("vec%0d data", idx), 32'(res_data), 32'(exp));
    check($sformatf("vec%0d id", idx), 32'(res_id), 32'(v.id));
    consume();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, shc, ng, cyc, prev;
    bit seen;
    int gid[4];
    int gcyc[4];

    //           id  sel     a        b        sh    exp_ms    exp_1
    vecs[0]  = '{1'b0, 3'b000, 16'h1234, 16'h0011, 4'd0,  16'h1245, 16'h1245};
    vecs[1]  = '{1'b1, 3'b001, 16'h0005, 16'h0007, 4'd0,  16'hFFFE, 16'hFFFE};
    vecs[2]  = '{1'b0, 3'b100, 16'hF0F0, 16'h0FF0, 4'd0,  16'hFF00, 16'hFF00};
    vecs[3]  = '{1'b1, 3'b010, 16'hF0F0, 16'h0FF0, 4'd0,  16'h00F0, 16'h00F0};
    vecs[4]  = '{1'b0, 3'b011, 16'hF0F0, 16'h0FF0, 4'd0,  16'hFFF0, 16'hFFF0};
    vecs[5]  = '{1'b1, 3'b101, 16'h1234, 16'h0000, 4'd0,  16'hEDCB, 16'hEDCB};
    vecs[6]  = '{1'b1, 3'b110, 16'h0001, 16'h0000, 4'd5,  16'h0020, 16'h0002};
    vecs[7]  = '{1'b1, 3'b110, 16'h0001, 16'h0000, 4'd0,  16'h0001, 16'h0002};
    vecs[8]  = '{1'b0, 3'b111, 16'h8000, 16'h0000, 4'd15, 16'h0001, 16'h4000};
    vecs[9]  = '{1'b0, 3'b110, 16'h00F0, 16'h0000, 4'd4,  16'h0F00, 16'h01E0};
    vecs[10] = '{1'b1, 3'b111, 16'hFFFF, 16'h0000, 4'd8,  16'h00FF, 16'h7FFF};
    vecs[11] = '{1'b0, 3'b110, 16'hABCD, 16'h0000, 4'd1,  16'h579A, 16'h579A};
    vecs[12] = '{1'b0, 3'b000, 16'h0001, 16'h0001, 4'd7,  16'h0002, 16'h0002};

    rst_n = 1'b0;
    res_ready = 1'b0;
    drive(1'b0, 1'b1, 3'b000, 16'h1111, 16'h2222, 4'd0);
    drive(1'b1, 1'b1, 3'b000, 16'h3333, 16'h4444, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst req_ready", {req0_ready, req1_ready}, 2'b00);
    check("rst res", {res_valid, res_id, res_data}, 18'h0);
    check("rst alu", {alu_a, alu_b, alu_sel, alu_shin}, 36'h0);
    drive(1'b0, 1'b0, 3'b000, 16'h0, 16'h0, 4'd0);
    drive(1'b1, 1'b0, 3'b000, 16'h0, 16'h0, 4'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) do_op(i, vecs[i]);

    // Tie arbitration after a fresh reset: grants alternate 0,1,0,1 at 3-cycle spacing.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 3'b001, 16'h0005, 16'h0007, 4'd0);
    drive(1'b1, 1'b1, 3'b100, 16'hF0F0, 16'h0FF0, 4'd0);
    res_ready = 1'b1;
    ng = 0;
    cyc = 0;
    while (ng < 4 && cyc < 40) begin
      #1;
      if (req0_ready || req1_ready) begin
        gid[ng] = req1_ready ? 1 : 0;
        gcyc[ng] = cyc;
        ng++;
      end
      if (res_valid)
        check($sformatf("rr data id%0d", res_id), 32'(res_data), res_id ? 32'h0000FF00 : 32'h0000FFFE);
      @(negedge clk);
      cyc++;
    end
    check("rr grant count", ng, 4);
    prev = -1;
    for (int i = 0; i < ng; i++) begin
      check($sformatf("rr grant%0d id", i), gid[i], i % 2);
      if (i > 0) check($sformatf("rr grant%0d spacing", i), gcyc[i] - prev, 3);
      prev = gcyc[i];
    end
    drive(1'b0, 1'b0, 3'b000, 16'h0, 16'h0, 4'd0);
    drive(1'b1, 1'b0, 3'b000, 16'h0, 16'h0, 4'd0);
    repeat (4) @(negedge clk);
    res_ready = 1'b0;
    check("rr drained", 32'(res_valid), 32'd0);

    // Backpressure: response held while req0 keeps asking.
    drive(1'b0, 1'b1, 3'b000, 16'h0002, 16'h0003, 4'd0);
    #1 check("bp accept", 32'(req0_ready), 32'd1);
    @(posedge clk);
    #1 drive(1'b0, 1'b1, 3'b000, 16'h0100, 16'h0001, 4'd0);
    wait_resp(lat, shc);
    check("bp first resp", 32'(res_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check($sformatf("bp hold%0d", i), {res_valid, res_id, req0_ready, res_data}, {3'b100, 16'h0005});
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    check("bp next accept ready", 32'(req0_ready), 32'd1);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 3'b000, 16'h0, 16'h0, 4'd0);
    wait_resp(lat, shc);
    check("bp second latency", lat, 2);
    check("bp second data", 32'(res_data), 32'h0101);
    consume();

    // Reset during a long shift from req0: no response, reset values, req0 wins next tie.
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b110, 16'h0003, 16'h0000, 4'd10);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 3'b000, 16'h0, 16'h0, 4'd0);
    repeat (MS ? 3 : 1) @(negedge clk);
    check("mid exec not done", 32'(res_valid), 32'd0);
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 3'b000, 16'h0001, 16'h0001, 4'd0);
    drive(1'b1, 1'b1, 3'b000, 16'h0009, 16'h0009, 4'd0);
    @(negedge clk); #1;
    check("mrst res", {res_valid, res_id, res_data}, 18'h0);
    check("mrst alu", {alu_a, alu_b, alu_sel, alu_shin}, 36'h0);
    check("mrst ready", {req0_ready, req1_ready}, 2'b00);
    drive(1'b0, 1'b0, 3'b000, 16'h0001, 16'h0001, 4'd0);
    drive(1'b1, 1'b0, 3'b000, 16'h0009, 16'h0009, 4'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("mrst no resp", 32'(seen), 32'd0);
    drive(1'b0, 1'b1, 3'b000, 16'h0001, 16'h0001, 4'd0);
    drive(1'b1, 1'b1, 3'b000, 16'h0009, 16'h0009, 4'd0);
    #1 check("mrst tie winner", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 3'b000, 16'h0, 16'h0, 4'd0);
    drive(1'b1, 1'b0, 3'b000, 16'h0, 16'h0, 4'd0);
    wait_resp(lat, shc);
    check("mrst post data", {res_id, res_data}, {1'b0, 16'h0002});
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Sequencer and round-robin arbiter that shares one combinational `ALU` instance (NBIT-wide, 3-bit `Sel`, 1-bit `shin`) between two requesters. Each requester presents an operation with valid/ready. The block grants one operation at a time and drives the ALU operand and select lines from registered state. Multi-bit shifts are executed as repeated single-bit ALU passes. The result is returned on a single valid/ready response port tagged with the requester ID.

## Interface
- `NBIT`, 16, datapath width; must match the attached ALU.
- `SHW`, 4, shift-amount width; equals clog2(NBIT).

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req0_valid` / `req1_valid` in 1: requester has an operation pending.
- `req0_ready` / `req1_ready` out 1: operation accepted this cycle when high together with valid.
- `req0_sel` / `req1_sel` in 3: ALU opcode, same encoding as ALU `Sel`. Codes 110 and 111 are shifts.
- `req0_a`, `req0_b` / `req1_a`, `req1_b` in NBIT: operands.
- `req0_shamt` / `req1_shamt` in SHW: shift amount; ignored for non-shift opcodes.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer takes the result.
- `res_id` out 1: requester that issued the result.
- `res_data` out NBIT: result value.
- `alu_a`, `alu_b` out NBIT: drive ALU `A` and `B`.
- `alu_sel` out 3: drives ALU `Sel`.
- `alu_shin` out 1: drives ALU `shin`.
- `alu_out` in NBIT: ALU `num_out`.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - `reqN_ready` is high only in IDLE and only for the arbitration winner. Ready is combinational from the valids and the priority pointer.
  - Arbitration is round-robin with a 1-bit `last` pointer. When both requesters are valid, the winner is the one not granted last.
  - When only one requester is valid, it wins.
  - On accept: latch `sel`, `a` into `acc`, `b`, `shamt` into `cnt`, and the requester ID. Toggle `last` to the winner. Go to EXEC.
- **EXEC**
  - ALU outputs driven from registers: `alu_a`=`acc`, `alu_b`=latched B, `alu_sel`=latched sel.
  - Non-shift opcode: one cycle. Capture `alu_out` into `res_data`, go to RESP. `alu_shin`=0.
  - Shift opcode, `cnt`==0: one cycle with `alu_shin`=0. Capture `alu_out` (equals A), go to RESP.
  - Shift opcode, `cnt`>0: `alu_shin`=1 each cycle. `acc`<=`alu_out`, `cnt`<=`cnt`-1. On the cycle where `cnt`==1, also capture into `res_data` and go to RESP.
  - Net effect: result = A shifted by `shamt` with zero fill. `shamt`≥NBIT cannot occur because of the SHW width.
- **RESP**
  - `res_valid`=1. `res_data` and `res_id` are held stable until `res_valid && res_ready`, then return to IDLE.
  - `alu_shin`=0 outside EXEC-shift cycles.
- Reset values:
  - `res_valid`=0, `res_data`=0, `res_id`=0.
  - `req0_ready`=`req1_ready`=0 while `rst_n`=0.
  - `alu_a`=`alu_b`=0, `alu_sel`=000, `alu_shin`=0.
  - `last`=1, so requester 0 wins the first tie.
  - `cnt`=0.
- Reset asserted mid-EXEC or mid-RESP: the operation and result are discarded and no response is issued. The state is IDLE on the edge after reset.
- Requester valids are not required to be held after accept. Changes to operands after accept have no effect.

## Timing
- Accept at edge k → `res_valid` high after edge k+1 for non-shift operations and shifts with `shamt`=0.
- Accept at edge k → `res_valid` high after edge k+`shamt` for shifts with `shamt`≥1.
- Response is held indefinitely under `res_ready`=0 backpressure.
- Return to IDLE happens on the handshake edge. A new accept is possible on the next edge.
- Minimum spacing between accepts is 3 cycles for non-shift operations with `res_ready` tied high.
- No combinational path from `alu_out` to any output; `res_data` is registered.

## Configuration
- `ALU_SCHED_MULTISHIFT_EN` defined: iterative multi-bit shifts as described above.
- `ALU_SCHED_MULTISHIFT_EN` undefined:
  - `shamt` ports are ignored and `cnt` logic is removed.
  - Shifts execute in a single EXEC cycle with `alu_shin`=1, giving a 1-bit shift.
  - Latency is 1 EXEC cycle for every opcode.

## Test plan
- Reset, then req0 `sel`=000, A=0x1234, B=0x0011 → `res_valid` one cycle after accept, `res_data`=0x1245, `res_id`=0.
- Both requesters valid continuously (req0: `sel`=001, A=5, B=7; req1: `sel`=100, A=0xF0F0, B=0x0FF0), `res_ready`=1 → grants alternate 0,1,0,1. Results are 0xFFFE and 0xFF00.
- req1 `sel`=110, A=0x0001, `shamt`=5 (macro defined) → 5 EXEC cycles with `alu_shin`=1, `res_data`=0x0020. Repeat with `shamt`=0 → `res_data`=0x0001 after 1 cycle.
- `sel`=111, A=0x8000, `shamt`=15 → `res_data`=0x0001. With the macro undefined, the same stimulus gives `res_data`=0x4000 after 1 cycle.
- Hold `res_ready`=0 for 10 cycles with req0 valid → `res_data` and `res_id` stay stable, `req0_ready`=0 throughout. Release → handshake, then IDLE and the next accept.
- Pull `rst_n` low during the EXEC of a `shamt`=10 shift → no `res_valid`. Outputs are at reset values on the next edge, and requester 0 wins the next tie.
